// File: rtl/pdm_mic_tx.sv
// PDM microphone emulator: buffers signed PCM samples and drives a first-order
// sigma-delta bit stream, one bit per synchronized rising edge of mic_clk.
`timescale 1ns/1ps
module pdm_mic_tx #(
    parameter int PCM_WIDTH       = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int BITS_PER_SAMPLE = 64,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PCM_WIDTH-1:0]          pcm_in,
    input  logic                          pcm_valid,
    output logic                          pcm_ready,
    input  logic                          mic_clk,
    output logic                          mic_pdm_data,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BITS_PER_SAMPLE > 1) ? $clog2(BITS_PER_SAMPLE) : 1;
    localparam logic [PCM_WIDTH-1:0] MIDSCALE = {1'b1, {(PCM_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]        LAST_BIT = CW'(BITS_PER_SAMPLE - 1);
    localparam logic [LW-1:0]        FULL_LVL = LW'(FIFO_DEPTH);

    // mic_clk synchronizer, history flop and registered rising-edge strobe
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_stb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            edge_stb <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], mic_clk};
            hist_q   <= sync_q[SYNC_STAGES-1];
            edge_stb <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    // Handshake: a sample is written on any clk edge where pcm_valid && pcm_ready;
    // pcm_ready depends only on the level register, never on pcm_valid.
    logic [PCM_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        bit_cnt;
    logic                 push;
    logic                 pop;
    logic                 boundary;
    logic                 fifo_empty;

    assign pcm_ready  = (fifo_level != FULL_LVL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = pcm_valid & pcm_ready;
    assign boundary   = edge_stb & (bit_cnt == LAST_BIT);
    // Pop looks only at the registered level, so a same-cycle push cannot satisfy it.
    assign pop        = boundary & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pcm_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // First-order modulator: the carry out of acc + cur is the output bit.
    logic [PCM_WIDTH-1:0] acc;
    logic [PCM_WIDTH-1:0] cur;
    logic [PCM_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, cur};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            cur          <= MIDSCALE;
            bit_cnt      <= '0;
            mic_pdm_data <= 1'b0;
        end else if (edge_stb) begin
            acc          <= sum[PCM_WIDTH-1:0];
            mic_pdm_data <= sum[PCM_WIDTH];
            bit_cnt      <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            if (pop) begin
                cur <= mem[rd_ptr] ^ MIDSCALE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (boundary && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_mic_tx.sv
// Bench for pdm_mic_tx: random PCM traffic against a running-sum density model,
// with a negedge-of-mic_clk monitor popping expected PDM bits from a queue.
`timescale 1ns/1ps
module tb_pdm_mic_tx;

    localparam int W   = 16;
    localparam int DEP = 4;
    localparam int BPS = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pcm_in = '0;
    logic         pcm_valid = 1'b0;
    logic         pcm_ready;
    logic         mic_clk = 1'b0;
    logic         mic_pdm_data;
    logic         underrun;
    logic         underrun_clr = 1'b0;
    logic [2:0]   fifo_level;

    pdm_mic_tx #(.PCM_WIDTH(W), .FIFO_DEPTH(DEP), .BITS_PER_SAMPLE(BPS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .mic_clk(mic_clk), .mic_pdm_data(mic_pdm_data),
        .underrun(underrun), .underrun_clr(underrun_clr), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the bit stream is the step count of floor(total/2^16),
    // where total is the sum of offset-binary sample values over all bits so far.
    longint unsigned m_total;
    logic [W-1:0]    m_cur;
    int              m_cnt;
    logic            m_prev;
    logic            m_under;
    logic [W-1:0]    m_fifo[$];
    logic [0:0]      exp_q[$];

    int mon_idx, win_lo, win_hi, ones_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_edge();
        longint unsigned nt;
        logic b;
        nt = m_total + 64'(m_cur);
        b = ((nt >> W) != (m_total >> W));
        m_total = nt;
        m_cnt++;
        if (m_cnt == BPS) begin
            m_cnt = 0;
            if (m_fifo.size() > 0) m_cur = m_fifo.pop_front() ^ 16'h8000;
            else m_under = 1'b1;
        end
        return b;
    endfunction

    // Monitor: receivers sample on the falling edge of mic_clk.
    initial begin
        forever begin
            @(negedge mic_clk);
            mon_idx++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got bit %0b expected none", mic_pdm_data);
            end else begin
                check("pdm_bit", 32'(mic_pdm_data), 32'(exp_q.pop_front()));
            end
            if (mon_idx >= win_lo && mon_idx <= win_hi && mic_pdm_data === 1'b1) ones_cnt++;
        end
    end

    task automatic model_reset();
        m_total = 0;
        m_cur = 16'h8000;
        m_cnt = 0;
        m_prev = 1'b0;
        m_under = 1'b0;
        m_fifo.delete();
        mon_idx = 0;
        ones_cnt = 0;
        win_lo = 0;
        win_hi = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pcm_valid = 1'b0;
        underrun_clr = 1'b0;
        mic_clk = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    // One mic_clk period per edge; rise phase jittered 1..8 ns inside a 10 ns cycle.
    task automatic run_edges(input int n, input bit clr_last);
        logic e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #($urandom_range(1, 8));
            mic_clk = 1'b1;
            e = model_edge();
            exp_q.push_back(e);
            repeat (3) @(posedge clk);
            #1;
            if (e != m_prev) check("latency_early", 32'(mic_pdm_data), 32'(m_prev));
            if (clr_last && k == n - 1) underrun_clr = 1'b1;
            @(posedge clk);
            #1;
            underrun_clr = 1'b0;
            if (e != m_prev) check("latency_bit", 32'(mic_pdm_data), 32'(e));
            m_prev = e;
            #($urandom_range(0, 8));
            mic_clk = 1'b0;
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic push_one(input logic [W-1:0] d);
        logic acc_exp;
        @(negedge clk);
        pcm_in = d;
        pcm_valid = 1'b1;
        acc_exp = (m_fifo.size() < DEP);
        check("pcm_ready_push", 32'(pcm_ready), 32'(acc_exp));
        if (acc_exp) m_fifo.push_back(d);
        @(posedge clk);
        #1 pcm_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state and midscale pattern
        do_reset();
        check("rst_pdm", 32'(mic_pdm_data), 0);
        check("rst_ready", 32'(pcm_ready), 1);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_underrun", 32'(underrun), 0);
        run_edges(8, 1'b0);

        // FIFO full: five back-to-back writes with pcm_valid held
        for (int i = 0; i < 5; i++) begin
            logic acc_exp;
            @(negedge clk);
            pcm_in = W'($urandom);
            pcm_valid = 1'b1;
            acc_exp = (m_fifo.size() < DEP);
            check("pcm_ready_burst", 32'(pcm_ready), 32'(acc_exp));
            if (acc_exp) m_fifo.push_back(pcm_in);
        end
        @(negedge clk);
        pcm_valid = 1'b0;
        check("full_level", 32'(fifo_level), 4);
        check("full_ready", 32'(pcm_ready), 0);
        run_edges(BPS - 8, 1'b0);
        check("after_pop_level", 32'(fifo_level), 3);
        check("after_pop_ready", 32'(pcm_ready), 1);

        // Density: PCM 0x4000 gives 192 ones in bits 65..320
        do_reset();
        push_one(16'h4000);
        win_lo = 65;
        win_hi = 320;
        run_edges(320, 1'b0);
        check("density_4000", 32'(ones_cnt), 192);

        // Density: most negative PCM gives no ones
        do_reset();
        push_one(16'h8000);
        win_lo = 65;
        win_hi = 128;
        run_edges(128, 1'b0);
        check("density_8000", 32'(ones_cnt), 0);

        // Underrun set, clear, and set-over-clear priority
        do_reset();
        push_one(W'($urandom));
        run_edges(127, 1'b0);
        check("underrun_before", 32'(underrun), 32'(m_under));
        run_edges(1, 1'b0);
        check("underrun_set", 32'(underrun), 1);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        m_under = 1'b0;
        check("underrun_clr", 32'(underrun), 0);
        run_edges(BPS - 1, 1'b0);
        check("underrun_quiet", 32'(underrun), 0);
        run_edges(1, 1'b1);
        check("underrun_priority", 32'(underrun), 1);

        // Random traffic
        do_reset();
        for (int r = 0; r < 6; r++) begin
            int np;
            np = $urandom_range(0, 5);
            for (int p = 0; p < np; p++) push_one(W'($urandom));
            run_edges($urandom_range(1, 100), 1'b0);
            check("rand_level", 32'(fifo_level), 32'(m_fifo.size()));
            check("rand_underrun", 32'(underrun), 32'(m_under));
        end

        // Mid-stream reset at bit_cnt 30 with 3 samples buffered
        do_reset();
        run_edges(BPS, 1'b0);
        for (int p = 0; p < 3; p++) push_one(W'($urandom));
        run_edges(30, 1'b0);
        check("pre_rst_level", 32'(fifo_level), 3);
        check("pre_rst_underrun", 32'(underrun), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_pdm", 32'(mic_pdm_data), 0);
        check("mid_rst_ready", 32'(pcm_ready), 1);
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_underrun", 32'(underrun), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        run_edges(4, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
